// File: rtl/spi_bpl_master_if.sv
// Command-side handshake and backplane SPI lines of spi_bpl_master, bundled so
// the master and its environment share one set of wires.
interface spi_bpl_master_if #(
  parameter int Nbit = 8
);
  logic            start;
  logic            wr;
  logic [6:0]      adr;
  logic [Nbit-1:0] wdata;
  logic            busy;
  logic            done;
  logic [Nbit-1:0] rdata;
  logic            cs;
  logic            sclk;
  logic            mosi;
  logic            miso;

  modport master (
    input  start, wr, adr, wdata, miso,
    output busy, done, rdata, cs, sclk, mosi
  );

  modport slave (
    output start, wr, adr, wdata, miso,
    input  busy, done, rdata, cs, sclk, mosi
  );
endinterface

// File: rtl/spi_bpl_master.sv
// Mode-0 SPI master for the backplane register slaves: one 8-bit header
// (R/W, 7-bit address) followed by an Nbit data word, MSB first.
module spi_bpl_master #(
  parameter int Nbit    = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 8
) (
  input  logic                clk,
  input  logic                rst,
  spi_bpl_master_if.master    io_bus
);

  localparam int T     = 8 + Nbit;
  localparam int CMAX  = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int BW    = $clog2(T + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bitcnt;
  logic [T-1:0]    r_sh;
  logic [Nbit-1:0] r_rsh;
  logic [Nbit-1:0] r_rdata;
  logic            r_cs;
  logic            r_sclk;
  logic            r_mosi;
  logic            r_busy;
  logic            r_done;

  logic            w_div_end;
  logic            w_gap_end;

  assign w_div_end = (r_cnt == CW'(CLK_DIV - 1));
  assign w_gap_end = (r_cnt == CW'(CS_IDLE - 1));

  // Every wire-level output is a register so the slaves see glitch-free edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_sh     <= {io_bus.wr, io_bus.adr, io_bus.wdata};
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_cs     <= 1'b0;
            r_busy   <= 1'b1;
            r_mosi   <= io_bus.wr;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP, S_LOW: begin
          if (w_div_end) begin
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          // First high cycle: count the bit and capture miso once the header is past.
          if (r_cnt == '0) begin
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt >= BW'(8)) begin
              r_rsh <= (r_rsh << 1) | Nbit'(io_bus.miso);
            end
          end
          if (w_div_end) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
            if (r_bitcnt == BW'(T)) begin
              r_state <= S_HOLD;
            end else begin
              r_sh    <= r_sh << 1;
              r_mosi  <= r_sh[T-2];
              r_state <= S_LOW;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_cnt   <= '0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_rdata <= r_rsh;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.busy  = r_busy;
  assign io_bus.done  = r_done;
  assign io_bus.rdata = r_rdata;
  assign io_bus.cs    = r_cs;
  assign io_bus.sclk  = r_sclk;
  assign io_bus.mosi  = r_mosi;

endmodule

// File: tb/tb_spi_bpl_master.sv
// Bench for spi_bpl_master: default instance plus a Nbit=16/CLK_DIV=5 instance,
// frames checked against wire-level timing and bit-order rules.
module tb_spi_bpl_master;

  localparam int CSI = 8;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic r_miso;

  always #5 clk = ~clk;

  spi_bpl_master_if #(.Nbit(8))  if0 ();
  spi_bpl_master_if #(.Nbit(16)) if1 ();

  assign if0.miso = r_miso;
  assign if1.miso = r_miso;

  spi_bpl_master #(.Nbit(8), .CLK_DIV(4), .CS_IDLE(CSI)) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (if0)
  );

  spi_bpl_master #(.Nbit(16), .CLK_DIV(5), .CS_IDLE(CSI)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (if1)
  );

  wire        w_cs    = sel ? if1.cs   : if0.cs;
  wire        w_sclk  = sel ? if1.sclk : if0.sclk;
  wire        w_mosi  = sel ? if1.mosi : if0.mosi;
  wire        w_busy  = sel ? if1.busy : if0.busy;
  wire        w_done  = sel ? if1.done : if0.done;
  wire [31:0] w_rdata = sel ? 32'(if1.rdata) : 32'(if0.rdata);

  int checks = 0;
  int errors = 0;

  int          n_rise, rise1, bad_w, cs_first, cs_last, done_cyc, done_cnt;
  logic [63:0] mwd;
  logic [31:0] rd_done;
  logic [31:0] slave_out;
  logic        busy_c1, mosi_c1, busy_done;

  typedef struct {
    logic        wr;
    logic [6:0]  adr;
    logic [7:0]  wd;
    logic [7:0]  mw;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_start(input bit s, input logic wr, input logic [6:0] adr,
                             input logic [31:0] wd);
    if (s) begin
      if1.wr = wr; if1.adr = adr; if1.wdata = wd[15:0]; if1.start = 1'b1;
    end else begin
      if0.wr = wr; if0.adr = adr; if0.wdata = wd[7:0];  if0.start = 1'b1;
    end
  endtask

  task automatic scramble();
    if0.wr = 1'($urandom); if0.adr = 7'($urandom); if0.wdata = 8'($urandom);
    if1.wr = 1'($urandom); if1.adr = 7'($urandom); if1.wdata = 16'($urandom);
  endtask

  // Runs one frame on the selected instance, acting as the miso-driving slave, and
  // checks it against the frame rules computed from the requested fields.
  task automatic run_frame(input bit s, input logic wr, input logic [6:0] adr,
                           input logic [31:0] wd, input logic [31:0] mw, input bit pulse50);
    int nb, d, tt, limit, last_rise, last_fall, nfall;
    logic ps, pcs;
    logic [7:0] hdr;
    logic [63:0] exp_word;
    logic [31:0] mask;
    nb = s ? 16 : 8;
    d  = s ? 5 : 4;
    tt = 8 + nb;
    mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 1);
    limit = 1 + (2 * tt + 1) * d + CSI + 10;
    n_rise = 0; rise1 = -1; bad_w = 0; cs_first = -1; cs_last = -1;
    done_cyc = -1; done_cnt = 0; mwd = '0; rd_done = '0;
    busy_c1 = 1'b0; mosi_c1 = 1'b0; busy_done = 1'b1;
    last_rise = 0; last_fall = 0; nfall = 0; ps = 1'b0; pcs = 1'b1;
    @(negedge clk);
    sel = s;
    r_miso = 1'($urandom);
    drive_start(s, wr, adr, wd);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if1.start = 1'b0;
      if (c == 1) begin
        scramble();
        busy_c1 = w_busy;
        mosi_c1 = w_mosi;
      end
      if (pulse50 && c == 50) begin
        chk("busy_at_50", 64'(w_busy), 64'd1);
        drive_start(s, ~wr, ~adr, ~wd);
      end
      if (!w_cs) begin
        if (cs_first < 0) cs_first = c;
        cs_last = c;
      end
      if (w_sclk && !ps) begin
        n_rise++;
        mwd = {mwd[62:0], w_mosi};
        if (rise1 < 0) rise1 = c;
        else if (c - last_rise != 2 * d) bad_w++;
        last_rise = c;
      end
      if (!w_sclk && ps) begin
        if (c - last_rise != d) bad_w++;
        nfall++;
        last_fall = c;
        if (nfall >= 8 && nfall - 8 < nb) r_miso = mw[nb - 1 - (nfall - 8)];
      end
      if (w_cs && !pcs) begin
        hdr = 8'(mwd >> nb);
        if (hdr[7] && hdr[6:0] == 7'h15) slave_out = 32'(mwd) & mask;
      end
      if (w_done) begin
        done_cnt++;
        done_cyc = c;
        rd_done = w_rdata;
        busy_done = w_busy;
      end
      ps  = w_sclk;
      pcs = w_cs;
      if (done_cyc > 0 && c >= done_cyc + 1) break;
    end
    exp_word = (64'({wr, adr}) << nb) | 64'(wd & mask);
    chk("busy_c1",   64'(busy_c1), 64'd1);
    chk("mosi_c1",   64'(mosi_c1), 64'(wr));
    chk("pulses",    64'(n_rise), 64'(tt));
    chk("mosi_bits", mwd, exp_word);
    chk("sclk_width", 64'(bad_w), 64'd0);
    chk("rise1",     64'(rise1), 64'(1 + d));
    chk("cs_first",  64'(cs_first), 64'd1);
    chk("cs_last",   64'(cs_last), 64'((2 * tt + 1) * d));
    chk("done_cyc",  64'(done_cyc), 64'(1 + (2 * tt + 1) * d + CSI));
    chk("done_cnt",  64'(done_cnt), 64'd1);
    chk("busy_done", 64'(busy_done), 64'd0);
    chk("rdata",     64'(rd_done), 64'(mw & mask));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows, dn, d1, d2, fall2, rise_cs1, c6;
    logic pcs, ps;
    tbl[0] = '{1'b1, 7'h15, 8'hA5, 8'h00, 16'h95A5, 8'h00};
    tbl[1] = '{1'b0, 7'h03, 8'h00, 8'h3C, 16'h0300, 8'h3C};
    tbl[2] = '{1'b1, 7'h7F, 8'hFF, 8'hFF, 16'hFFFF, 8'hFF};
    tbl[3] = '{1'b0, 7'h00, 8'h00, 8'h81, 16'h0000, 8'h81};
    tbl[4] = '{1'b1, 7'h2A, 8'h01, 8'h80, 16'hAA01, 8'h80};

    sel = 1'b0; r_miso = 1'b0; slave_out = '0;
    if0.start = 1'b0; if0.wr = 1'b0; if0.adr = '0; if0.wdata = '0;
    if1.start = 1'b0; if1.wr = 1'b0; if1.adr = '0; if1.wdata = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs",    64'(if0.cs), 64'd1);
    chk("rst_sclk",  64'(if0.sclk), 64'd0);
    chk("rst_mosi",  64'(if0.mosi), 64'd1);
    chk("rst_busy",  64'(if0.busy), 64'd0);
    chk("rst_done",  64'(if0.done), 64'd0);
    chk("rst_rdata", 64'(if0.rdata), 64'd0);
    chk("rst_cs1",   64'(if1.cs), 64'd1);

    // start together with rst: no frame
    if0.start = 1'b1; if0.wr = 1'b1; if0.adr = 7'h15; if0.wdata = 8'h11;
    @(negedge clk);
    rst = 1'b0; if0.start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 64'(if0.busy), 64'd0);
    chk("rst_start_cs",   64'(if0.cs), 64'd1);

    // Table vectors on the default instance
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b0, tbl[i].wr, tbl[i].adr, 32'(tbl[i].wd), 32'(tbl[i].mw), 1'b0);
      chk("tbl_mosi",  mwd, 64'(tbl[i].exp_mosi));
      chk("tbl_rdata", 64'(rd_done), 64'(tbl[i].exp_rd));
      if (i == 0) chk("slave_out_A5", 64'(slave_out), 64'h0A5);
    end

    // Abort at the 6th rising sclk edge
    @(negedge clk);
    sel = 1'b0;
    drive_start(1'b0, 1'b1, 7'h15, 32'h33);
    n = 0; ps = 1'b0; c6 = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if (if0.sclk && !ps) n++;
      ps = if0.sclk;
      if (n == 6) begin c6 = c; break; end
    end
    chk("abort_rise6_cycle", 64'(c6), 64'(1 + 4 + 5 * 8));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs",    64'(if0.cs), 64'd1);
    chk("abort_sclk",  64'(if0.sclk), 64'd0);
    chk("abort_mosi",  64'(if0.mosi), 64'd1);
    chk("abort_busy",  64'(if0.busy), 64'd0);
    chk("abort_rdata", 64'(if0.rdata), 64'd0);
    dn = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (if0.done || !if0.cs) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run_frame(1'b0, 1'b1, 7'h15, 32'h5A, 32'hC3, 1'b0);
    chk("slave_out_5A", 64'(slave_out), 64'h05A);

    // Second start during a frame is ignored
    run_frame(1'b0, 1'b1, 7'h44, 32'h96, 32'h69, 1'b1);
    lows = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!if0.cs || if0.busy) lows++;
    end
    chk("ignored_start", 64'(lows), 64'd0);

    // start held high: next frame accepted on the cycle after done
    @(negedge clk);
    sel = 1'b0;
    drive_start(1'b0, 1'b0, 7'h03, 32'h00);
    d1 = -1; d2 = -1; fall2 = -1; rise_cs1 = -1; pcs = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (if0.cs && !pcs && rise_cs1 < 0) rise_cs1 = c;
      if (!if0.cs && pcs && d1 > 0 && fall2 < 0) fall2 = c;
      if (if0.done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      if (fall2 > 0) if0.start = 1'b0;
      pcs = if0.cs;
      if (d2 > 0) break;
    end
    chk("b2b_cs_rise", 64'(rise_cs1), 64'd133);
    chk("b2b_done1",   64'(d1), 64'd141);
    chk("b2b_fall2",   64'(fall2), 64'(d1 + 2));
    chk("b2b_done2",   64'(d2), 64'(d1 + 1 + 141));

    // Randomized frames against the frame model
    for (int i = 0; i < 16; i++) begin
      run_frame(1'b0, 1'($urandom), 7'($urandom), 32'($urandom), 32'($urandom), 1'b0);
    end

    // Wide instance: Nbit=16, CLK_DIV=5
    run_frame(1'b1, 1'b1, 7'h15, 32'hBEEF, 32'h1234, 1'b0);
    chk("sweep_cs_high", 64'(cs_last + 1), 64'd246);
    chk("sweep_done",    64'(done_cyc), 64'd254);
    chk("sweep_slave",   64'(slave_out), 64'hBEEF);
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b1, 1'($urandom), 7'($urandom), 32'($urandom), 32'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
